// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, stall bus indices.
package muldiv_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // Bit positions in the pipeline-wide stall bus
  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned restoring radix-2 divider; the first quotient bit is produced on the start edge,
// so ready_o rises DATA_W cycles after start_i. abort_i drops an operation in flight.
module div_radix2_core
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dsr_q, quo_q, rem_q;
  logic [DATA_W-1:0] dsr, quo_cur, rem_cur, quo_nxt, rem_nxt;
  logic [DATA_W:0]   trial, diff;

  // quo register doubles as the dividend shifter: dividend bits leave at the top,
  // quotient bits enter at the bottom
  always_comb begin
    dsr     = start_i ? divisor_i : dsr_q;
    quo_cur = start_i ? dividend_i : quo_q;
    rem_cur = start_i ? '0 : rem_q;
    trial   = {rem_cur, quo_cur[DATA_W-1]};
    diff    = trial - {1'b0, dsr};
    if (!diff[DATA_W]) begin
      rem_nxt = diff[DATA_W-1:0];
      quo_nxt = {quo_cur[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[DATA_W-1:0];
      quo_nxt = {quo_cur[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i || busy_q) begin
      dsr_q  <= dsr;
      quo_q  <= quo_nxt;
      rem_q  <= rem_nxt;
      cnt_q  <= start_i ? CNT_W'(1) : cnt_q + 1'b1;
      busy_q <= start_i ? 1'b1 : (cnt_q != CNT_W'(DATA_W - 1));
    end
  end

  assign ready_o = !busy_q;
  assign quot_o  = quo_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/ex_muldiv_hilo.sv
// EX-stage MULT/DIV unit with HI/LO: DATA_W+1 cycle latency (1 for div-by-zero or MULDIV_FAST_MUL_EN),
// holds EX via stallreq_o while busy, parks in DONE under stall_i and commits HI/LO on leaving DONE.
module ex_muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              annul_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              stallreq_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        hilo_we_o,
  output logic [DATA_W-1:0] hi_wdata_o,
  output logic [DATA_W-1:0] lo_wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_res_q, neg_rem_q;
  logic [DATA_W-1:0]   mcand_q, res_hi_q, res_lo_q, hi_q, lo_q;
  logic [2*DATA_W-1:0] prod_q, prod_step, prod_fin, fast_prod, fast_res;
  logic [DATA_W:0]     sum;

  logic              is_mul, is_div, is_signed, s1_neg, s2_neg, div_zero, accept;
  logic [DATA_W-1:0] a1, a2, div_q, div_r, q_fix, r_fix;
  logic              div_ready, div_start;

  assign is_mul    = (op_i == MD_MULT) || (op_i == MD_MULTU);
  assign is_div    = (op_i == MD_DIV)  || (op_i == MD_DIVU);
  assign is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign s1_neg    = is_signed && src1_i[DATA_W-1];
  assign s2_neg    = is_signed && src2_i[DATA_W-1];
  assign a1        = s1_neg ? -src1_i : src1_i;
  assign a2        = s2_neg ? -src2_i : src2_i;
  assign div_zero  = (src2_i == '0);
  assign accept    = (state_q == IDLE) && start_i && !annul_i && (is_mul || is_div);
  assign div_start = accept && is_div && !div_zero;

  // Shift-add: low half holds the unconsumed multiplier, high half the partial sum
  assign sum       = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {sum, prod_q[DATA_W-1:1]};
  assign prod_fin  = neg_res_q ? -prod_step : prod_step;
  assign fast_prod = {{DATA_W{1'b0}}, a1} * {{DATA_W{1'b0}}, a2};
  assign fast_res  = (s1_neg ^ s2_neg) ? -fast_prod : fast_prod;
  assign q_fix     = neg_res_q ? -div_q : div_q;
  assign r_fix     = neg_rem_q ? -div_r : div_r;

  div_radix2_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .abort_i    (annul_i),
    .dividend_i (a1),
    .divisor_i  (a2),
    .ready_o    (div_ready),
    .quot_o     (div_q),
    .rem_o      (div_r)
  );

  always_comb begin
    state_d    = state_q;
    hilo_we_o  = 2'b00;
    hi_wdata_o = '0;
    lo_wdata_o = '0;
    stallreq_o = (state_q == MUL) || (state_q == DIV) || accept;
    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            state_d = DONE;
`else
            state_d = MUL;
`endif
          end else if (start_i && is_div) begin
            state_d = div_zero ? DONE : DIV;
          end else if (start_i && !stall_i && op_i == MD_MTHI) begin
            hilo_we_o  = 2'b10;
            hi_wdata_o = src1_i;
          end else if (start_i && !stall_i && op_i == MD_MTLO) begin
            hilo_we_o  = 2'b01;
            lo_wdata_o = src1_i;
          end
        end
        MUL: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        DIV: if (div_ready) state_d = DONE;
        DONE: begin
          if (!stall_i) begin
            state_d    = IDLE;
            hilo_we_o  = 2'b11;
            hi_wdata_o = res_hi_q;
            lo_wdata_o = res_lo_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      if (hilo_we_o[1]) hi_q <= hi_wdata_o;
      if (hilo_we_o[0]) lo_q <= lo_wdata_o;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            mcand_q   <= a1;
            prod_q    <= {{DATA_W{1'b0}}, a2};
            neg_res_q <= s1_neg ^ s2_neg;
            neg_rem_q <= s1_neg;
            if (is_div && div_zero) begin
              res_hi_q <= src1_i;
              res_lo_q <= '1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (is_mul) begin
              {res_hi_q, res_lo_q} <= fast_res;
            end
`endif
          end
        end
        MUL: begin
          if (!annul_i) begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) {res_hi_q, res_lo_q} <= prod_fin;
          end
        end
        DIV: if (!annul_i && div_ready) {res_hi_q, res_lo_q} <= {r_fix, q_fix};
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Self-checking bench for ex_muldiv_hilo: directed vector table, random ops against an arithmetic model,
// and hand sequences for stall-in-DONE, annul, MTHI/MTLO and mid-operation reset.
module tb_ex_muldiv_hilo;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, stall_i, annul_i, start_i;
  logic [2:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        stallreq_o, busy_o, done_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_wdata_o, lo_wdata_o, hi_o, lo_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo;

  ex_muldiv_hilo #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .annul_i(annul_i), .start_i(start_i),
    .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i), .stallreq_o(stallreq_o),
    .busy_o(busy_o), .done_o(done_o), .hilo_we_o(hilo_we_o), .hi_wdata_o(hi_wdata_o),
    .lo_wdata_o(lo_wdata_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); {hi, lo} = p; end
      MD_MULTU: begin p = {32'h0, a} * {32'h0, b}; {hi, lo} = p; end
      MD_DIV: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      end
      MD_DIVU: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
    if (op == MD_DIV || op == MD_DIVU) return (b == 0) ? 1 : DIV_LAT;
    return MUL_LAT;
  endfunction

  // Called just after a negedge; returns just after a negedge with start_i low.
  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int elat);
    int lat;
    bit prof_ok;
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    #1 chk({nm, "_stallreq_c0"}, 64'(stallreq_o), 64'd1);
    lat = 0;
    prof_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done_o || lat >= 100) break;
      if (!stallreq_o || !busy_o || hilo_we_o != 2'b00 || hi_o !== m_hi || lo_o !== m_lo) prof_ok = 1'b0;
    end
    start_i = 1'b0;
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_busy_profile"}, 64'(prof_ok), 64'd1);
    #1;
    chk({nm, "_stallreq_done"}, 64'(stallreq_o), 64'd0);
    chk({nm, "_we"}, 64'(hilo_we_o), 64'd3);
    chk({nm, "_hi_wdata"}, 64'(hi_wdata_o), 64'(ehi));
    chk({nm, "_lo_wdata"}, 64'(lo_wdata_o), 64'(elo));
    @(negedge clk);
    m_hi = ehi;
    m_lo = elo;
    chk({nm, "_hi"}, 64'(hi_o), 64'(ehi));
    chk({nm, "_lo"}, 64'(lo_o), 64'(elo));
    chk({nm, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[10];
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          lat;

    vecs[0] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[2] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT};
    vecs[3] = '{MD_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1};
    vecs[4] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT};
    vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT};
    vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
    vecs[7] = '{MD_DIV,   32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 1};
    vecs[8] = '{MD_MULTU, 32'd0,        32'd12345,    32'd0,        32'd0,        MUL_LAT};
    vecs[9] = '{MD_DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        DIV_LAT};

    m_hi = '0; m_lo = '0;
    rst = 1'b1; stall_i = 1'b0; annul_i = 1'b0; start_i = 1'b0;
    op_i = MD_NOP; src1_i = '0; src2_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_stallreq", 64'(stallreq_o), 64'd0);
    chk("reset_we", 64'(hilo_we_o), 64'd0);
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].lat);

    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      model(op, a, b, ehi, elo);
      do_op($sformatf("rnd%0d", i), op, a, b, ehi, elo, lat_of(op, b));
    end

    // MTLO writes the same cycle; MTHI under stall must not write
    op_i = MD_MTLO; src1_i = 32'h1234; start_i = 1'b1;
    #1;
    chk("mtlo_we", 64'(hilo_we_o), 64'd1);
    chk("mtlo_wdata", 64'(lo_wdata_o), 64'h1234);
    chk("mtlo_stallreq", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    m_lo = 32'h1234;
    chk("mtlo_lo", 64'(lo_o), 64'h1234);
    chk("mtlo_hi_kept", 64'(hi_o), 64'(m_hi));
    op_i = MD_MTHI; src1_i = 32'hABCD; start_i = 1'b1; stall_i = 1'b1;
    #1 chk("mthi_stalled_we", 64'(hilo_we_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0; stall_i = 1'b0;
    chk("mthi_stalled_hi", 64'(hi_o), 64'(m_hi));
    chk("mthi_stalled_busy", 64'(busy_o), 64'd0);

    // DIV 100/7 held in DONE for 3 cycles with start_i still high
    op_i = MD_DIV; src1_i = 32'd100; src2_i = 32'd7; start_i = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done_o || lat >= 100) break;
    end
    chk("hold_latency", 64'(lat), 64'(DIV_LAT));
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold_we_%0d", k), 64'(hilo_we_o), 64'd0);
      chk($sformatf("hold_done_%0d", k), 64'(done_o), 64'd1);
      @(negedge clk);
    end
    stall_i = 1'b0; start_i = 1'b0;
    #1;
    chk("hold_release_we", 64'(hilo_we_o), 64'd3);
    chk("hold_release_hi_wdata", 64'(hi_wdata_o), 64'd2);
    chk("hold_release_lo_wdata", 64'(lo_wdata_o), 64'd14);
    @(negedge clk);
    m_hi = 32'd2; m_lo = 32'd14;
    chk("hold_hi", 64'(hi_o), 64'd2);
    chk("hold_lo", 64'(lo_o), 64'd14);
    chk("hold_idle", 64'(busy_o), 64'd0);

    // Annul at iteration 10 of a DIVU, then a MULTU straight after
    op_i = MD_DIVU; src1_i = 32'd1000; src2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    #1 chk("annul_we", 64'(hilo_we_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_idle", 64'(busy_o), 64'd0);
    chk("annul_hi_kept", 64'(hi_o), 64'(m_hi));
    chk("annul_lo_kept", 64'(lo_o), 64'(m_lo));
    do_op("annul_multu", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

    // Annul coinciding with DONE->IDLE suppresses the commit
    op_i = MD_DIVU; src1_i = 32'd9; src2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    chk("annul_done_state", 64'(done_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    #1 chk("annul_done_we", 64'(hilo_we_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_done_idle", 64'(done_o), 64'd0);
    chk("annul_done_hi", 64'(hi_o), 64'(m_hi));
    chk("annul_done_lo", 64'(lo_o), 64'(m_lo));

    // Reset in the middle of a DIV
    op_i = MD_DIV; src1_i = 32'd500; src2_i = 32'd3; start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    chk("rst_mid_stallreq", 64'(stallreq_o), 64'd0);
    chk("rst_mid_we", 64'(hilo_we_o), 64'd0);
    chk("rst_mid_wdata", 64'({hi_wdata_o, lo_wdata_o}), 64'd0);
    chk("rst_mid_hi", 64'(hi_o), 64'd0);
    chk("rst_mid_lo", 64'(lo_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_hilo.md
Name: ex_muldiv_hilo

Overview:
- Parametrised multiply/divide unit with its own HI/LO register pair, instantiated inside the EX stage of the 5-stage pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
- Holds EX through a stall request while busy, and commits HI/LO when the instruction leaves EX.
- Exposes the commit write port so ID can forward pending HI/LO values.

Parameters:
DATA_W, 32, operand width; HI and LO are DATA_W bits each
CNT_W, $clog2(DATA_W)+1, iteration counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_i  in  1  pipeline hold from a later stage (EX must not advance)
annul_i  in  1  flush; abandons the operation in progress
start_i  in  1  valid HI/LO-class instruction present in EX
op_i  in  3  operation code, encodings in shared package
src1_i  in  DATA_W  rs value (dividend / multiplicand / MTHI-MTLO data)
src2_i  in  DATA_W  rt value (divisor / multiplier)
stallreq_o  out  1  request to stall IF..EX
busy_o  out  1  FSM not IDLE
done_o  out  1  result valid (state DONE)
hilo_we_o  out  2  {hi_we, lo_we} commit strobe this cycle
hi_wdata_o  out  DATA_W  HI commit data
lo_wdata_o  out  DATA_W  LO commit data
hi_o  out  DATA_W  committed HI
lo_o  out  DATA_W  committed LO

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. On reset: state IDLE, counter 0, HI=LO=0, every output 0.
- FSM states:
  - IDLE → MUL when start_i and op is MULT/MULTU.
  - IDLE → DIV when start_i and op is DIV/DIVU with nonzero divisor.
  - IDLE → DONE when the divisor is 0, or with FAST_MUL_EN for mult ops.
  - MUL/DIV → DONE after DATA_W iterations.
  - DONE → IDLE when stall_i=0.
  - Any state → IDLE on annul_i; annul overrides everything.
- Accept: operands and op are latched at the IDLE edge. Signed ops latch absolute values plus result-sign flags.
- Multiply: shift-add, one multiplier bit per cycle. 2·DATA_W-bit product, HI=upper, LO=lower. Signed result negated at DONE entry when the operand signs differ.
- Divide: restoring radix-2, one quotient bit per cycle. LO=quotient, HI=remainder. Quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero: no iterations; DONE next cycle with LO=all ones, HI=src1_i.
- Latency: accept at cycle 0, DONE visible at cycle DATA_W+1 (cycle 1 for div-by-zero or FAST_MUL).
- stallreq_o:
  - high combinationally in IDLE when start_i and op is mul/div and annul_i=0;
  - high throughout MUL/DIV;
  - low in DONE, which releases EX.
- Commit: HI/LO are written on the DONE→IDLE edge only. hilo_we_o=2'b11 and the wdata outputs are driven during that cycle (DONE and stall_i=0). No write while stall_i holds DONE, and no write on annul.
- MTHI/MTLO: in IDLE with start_i, no stall, no state change. hilo_we_o=2'b10/2'b01 with wdata=src1_i combinationally, registered at that edge; suppressed if stall_i or annul_i.
- start_i outside IDLE is ignored. EX keeps start_i high while stalled, so DONE must not restart.
- Simultaneous annul_i and DONE→IDLE: annul wins, no commit.
- busy_o = state≠IDLE. done_o = state==DONE.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle `*` product registered at accept; IDLE→DONE, latency 1, stallreq_o high only in the accept cycle.
- Undefined: iterative shift-add multiply as above, latency DATA_W+1.
- Divide and commit behaviour are identical in both builds.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6;
  - state encoding IDLE/MUL/DIV/DONE;
  - StallBus index constants.
- Sub-module div_radix2_core: iterative divide datapath with start/ready handshake. The FSM, multiplier and HI/LO registers stay in the top module.

Test Plan:
- DIV src1=-7 (0xFFFFFFF9), src2=2 → stallreq_o high cycles 0..32, done_o at cycle 33; commit LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT -3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Check latency in both MULDIV_FAST_MUL_EN builds.
- DIVU 100/0 → done_o at cycle 1, LO=0xFFFFFFFF, HI=100, stallreq_o high only in cycle 0.
- DIV 100/7 with stall_i held 3 cycles in DONE → hilo_we_o stays 0 until stall_i drops, then one 2'b11 pulse with HI=2, LO=14; start_i still high does not restart.
- annul_i at iteration 10 of a DIVU → IDLE next cycle, HI/LO unchanged, no commit pulse; a new MULTU is accepted immediately after.
- MTLO 0x1234 then MFHI-style read: hilo_we_o=2'b01 with lo_wdata_o=0x1234 the same cycle, lo_o=0x1234 next cycle. Reset mid-DIV → IDLE, HI=LO=0, all outputs 0.
